// File: rtl/edabk_receiver_if.sv
// ============================================================================
// Module      : edabk_receiver_if
// Description : Serial-line and receive-FIFO handshake bundle for the
//               edabk UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

interface edabk_receiver_if #(
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH
);
    logic                  tick;
    logic                  parity;
    logic                  rx_in;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rx_out;
    logic                  valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun;

    // Driver side: baud tick, line, configuration and consumer pop.
    modport master (
        output tick, parity, rx_in, rd,
        input  rx_out, valid, parity_err, frame_err, overrun
    );

    // Receiver side.
    modport slave (
        input  tick, parity, rx_in, rd,
        output rx_out, valid, parity_err, frame_err, overrun
    );
endinterface

`default_nettype wire

// File: rtl/edabk_receiver.sv
// ============================================================================
// Module      : edabk_receiver
// Description : UART receiver with OVERSAMPLE x oversampling. Frame is start
//               bit, DATA_WIDTH data bits LSB-first, optional even parity,
//               one stop bit. Holds the last word with a valid/rd handshake
//               and reports parity, framing and overrun errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_receiver #(
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    edabk_receiver_if.slave bus
);

    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [c_IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   perr_q, perr_d;
    logic [DATA_WIDTH-1:0]  rx_out_q, rx_out_d;
    logic                   valid_q, valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    logic                   w_rx_s;
    logic                   w_centre;

    assign w_rx_s   = sync2_q;
    assign w_centre = (cnt_q == c_CNT_FULL);

    // State, counters, synchronizer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            perr_q       <= 1'b0;
            rx_out_q     <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= bus.rx_in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            perr_q       <= perr_d;
            rx_out_q     <= rx_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame FSM, bit sampling and the consumer handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        perr_d       = perr_q;
        rx_out_d     = rx_out_q;
        valid_d      = valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        // A pop only matters when a word is held; a commit below overrides it.
        if (bus.rd && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (bus.tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == c_CNT_HALF) begin
                        if (!w_rx_s) begin
                            state_d   = S_DATA;
                            cnt_d     = '0;
                            bit_idx_d = '0;
                            par_en_d  = bus.parity;
                            perr_d    = 1'b0;
                        end else begin
                            // Start bit gone by its centre: treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_centre) begin
                        shift_d   = {w_rx_s, shift_q[DATA_WIDTH-1:1]};
                        cnt_d     = '0;
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == c_IDX_LAST) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_centre) begin
                        perr_d  = w_rx_s ^ (^shift_q);
                        cnt_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_centre) begin
                        rx_out_d     = shift_q;
                        valid_d      = 1'b1;
                        parity_err_d = perr_q;
                        frame_err_d  = ~w_rx_s;
                        // Unread word lost, unless it is popped on this same edge.
                        if (valid_q && !bus.rd) begin
                            overrun_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = w_rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Wait for the line to recover so a held-low line is not a new start.
                    if (w_rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_out     = rx_out_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_edabk_receiver.sv
// ============================================================================
// Module      : tb_edabk_receiver
// Description : Directed testbench for edabk_receiver (8 data bits, 16x
//               oversampling, tick every second clock).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edabk_receiver;

    localparam int c_BIT_CLK = 32;   // 16 ticks x 2 clk per tick

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   rd_k;       // cycle offset within a frame at which rd is pulsed, -1 = never
    int   commit_k;   // cycle offset at which valid was first seen rising
    int   lat;

    edabk_receiver_if #(.DATA_WIDTH(8)) bus ();

    edabk_receiver #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (16)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: high for one clock out of every two.
    initial begin
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.tick = ~bus.tick;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the first nbits of lv (bit 0 first), one bit period each,
    // starting aligned to a tick. Handles rd_k and records commit_k.
    task automatic send_bits(input logic [15:0] lv, input int nbits);
        logic vprev;
        vprev    = bus.valid;
        commit_k = -1;
        do @(negedge clk); while (bus.tick !== 1'b1);
        for (int k = 0; k < nbits * c_BIT_CLK; k++) begin
            if (k > 0) @(negedge clk);
            bus.rx_in = lv[k / c_BIT_CLK];
            bus.rd    = (k == rd_k);
            if (!vprev && bus.valid && commit_k < 0) commit_k = k;
            vprev = bus.valid;
        end
        @(negedge clk);
        bus.rd = 1'b0;
        if (!vprev && bus.valid && commit_k < 0) commit_k = nbits * c_BIT_CLK;
    endtask

    task automatic hold(input logic level, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            bus.rx_in = level;
        end
    endtask

    // Full frame: start, 8 data bits, optional parity bit, stop bit, then idle.
    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic pb, input logic sb);
        if (use_par) send_bits({5'b0, sb, pb, d, 1'b0}, 11);
        else         send_bits({6'b0, sb, d, 1'b0}, 10);
        if (sb) hold(1'b1, c_BIT_CLK);
    endtask

    task automatic pulse_rd;
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rd_k       = -1;
        commit_k   = -1;
        lat        = 0;
        reset      = 1'b1;
        bus.parity = 1'b0;
        bus.rx_in  = 1'b1;
        bus.rd     = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        hold(1'b1, 8);

        check("reset rx_out", 32'(bus.rx_out), 32'h00);
        check("reset valid", 32'(bus.valid), 32'h0);
        check("reset flags", {29'b0, bus.parity_err, bus.frame_err, bus.overrun}, 32'h0);

        // Plain 8N1 frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check("A5 rx_out", 32'(bus.rx_out), 32'hA5);
        check("A5 valid", 32'(bus.valid), 32'h1);
        check("A5 flags", {29'b0, bus.parity_err, bus.frame_err, bus.overrun}, 32'h0);
        pulse_rd();
        check("A5 rd clears valid", 32'(bus.valid), 32'h0);

        // Even parity: 0xAB has five ones, so parity bit 1 is correct
        bus.parity = 1'b1;
        send_frame(8'hAB, 1'b1, 1'b1, 1'b1);
        check("AB good par rx_out", 32'(bus.rx_out), 32'hAB);
        check("AB good par err", 32'(bus.parity_err), 32'h0);
        pulse_rd();
        send_frame(8'hAB, 1'b1, 1'b0, 1'b1);
        check("AB bad par rx_out", 32'(bus.rx_out), 32'hAB);
        check("AB bad par err", 32'(bus.parity_err), 32'h1);
        check("AB bad par ferr", 32'(bus.frame_err), 32'h0);
        pulse_rd();
        bus.parity = 1'b0;

        // Start glitch: 4 ticks low, then high
        send_bits(16'h0000, 0);
        hold(1'b0, 8);
        hold(1'b1, 3 * c_BIT_CLK);
        check("glitch valid", 32'(bus.valid), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check("3C rx_out", 32'(bus.rx_out), 32'h3C);
        check("3C valid", 32'(bus.valid), 32'h1);
        pulse_rd();

        // Low stop bit followed by a held-low line
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 3 * c_BIT_CLK);
        check("0F rx_out", 32'(bus.rx_out), 32'h0F);
        check("0F frame_err", 32'(bus.frame_err), 32'h1);
        check("0F valid", 32'(bus.valid), 32'h1);
        pulse_rd();
        hold(1'b0, 2 * c_BIT_CLK);
        check("break no spurious", 32'(bus.valid), 32'h0);
        hold(1'b1, 2 * c_BIT_CLK);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        check("55 rx_out", 32'(bus.rx_out), 32'h55);
        check("55 frame_err", 32'(bus.frame_err), 32'h0);
        pulse_rd();

        // Overrun
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        check("11 overrun", 32'(bus.overrun), 32'h0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        check("22 rx_out", 32'(bus.rx_out), 32'h22);
        check("22 valid", 32'(bus.valid), 32'h1);
        check("22 overrun", 32'(bus.overrun), 32'h1);
        pulse_rd();
        check("rd clears valid", 32'(bus.valid), 32'h0);
        check("rd clears overrun", 32'(bus.overrun), 32'h0);

        // Locate the commit edge (frame starts on the same tick phase every time)
        send_frame(8'h44, 1'b0, 1'b0, 1'b1);
        check("44 rx_out", 32'(bus.rx_out), 32'h44);
        check("commit seen", 32'(commit_k >= 0), 32'h1);
        lat = commit_k;
        // 0x44 left unread; pop coincides with the commit of 0x33
        rd_k = lat - 1;
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        rd_k = -1;
        check("33 rx_out", 32'(bus.rx_out), 32'h33);
        check("33 valid", 32'(bus.valid), 32'h1);
        check("33 overrun", 32'(bus.overrun), 32'h0);

        // Reset halfway through data bit 4 of 0xFF
        send_bits(16'b11110, 5);
        hold(1'b1, c_BIT_CLK / 2);
        reset = 1'b1;
        hold(1'b1, 2);
        reset = 1'b0;
        hold(1'b1, 1);
        check("mid reset rx_out", 32'(bus.rx_out), 32'h00);
        check("mid reset valid", 32'(bus.valid), 32'h0);
        check("mid reset flags", {29'b0, bus.parity_err, bus.frame_err, bus.overrun}, 32'h0);
        hold(1'b1, 2 * c_BIT_CLK);
        check("no frame after reset", 32'(bus.valid), 32'h0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        check("81 rx_out", 32'(bus.rx_out), 32'h81);
        check("81 valid", 32'(bus.valid), 32'h1);
        check("81 flags", {29'b0, bus.parity_err, bus.frame_err, bus.overrun}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/edabk_receiver.md
Name: edabk_receiver

Overview:
UART serial receiver, the receive-side counterpart of the transceiver's transmitter. Recovers frames from the serial line using 16x oversampling:
- start bit, DATA_WIDTH data bits LSB-first, optional even-parity bit, one stop bit.
- Received words are held in an output register with a valid/rd handshake toward the receive FIFO.
- Reports parity, framing and overrun errors.

Parameters:
DATA_WIDTH, `CFG_DATA_WIDTH (8), data bits per frame
OVERSAMPLE, 16, tick pulses per bit period (power of 2, >= 8)

Ports:
clk          input   1           system clock, all logic on rising edge
reset        input   1           synchronous, active-high reset
tick         input   1           one-clk enable pulse at OVERSAMPLE x baud rate
parity       input   1           1 = parity bit expected (even parity); latched at start-bit confirm
rx_in        input   1           asynchronous serial line, idle high
rd           input   1           consumer pop; clears valid
rx_out       output  DATA_WIDTH  last received word
valid        output  1           rx_out holds an unread word
parity_err   output  1           parity mismatch on the word in rx_out
frame_err    output  1           stop bit sampled low on the word in rx_out
overrun      output  1           sticky: a word was overwritten before rd

Behaviour:
- Reset values: rx_out=0, valid=0, parity_err=0, frame_err=0, overrun=0, state=IDLE, synchronizer flops=1, counters=0.
- rx_in passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s and occurs only on clk edges with tick=1.
- cnt: log2(OVERSAMPLE)-bit tick counter. bit_idx: data-bit counter. shift: DATA_WIDTH shift register, LSB-first fill.
- IDLE: tick & rx_s==0 -> START, cnt=0.
- START: increment cnt on each tick.
  - At cnt==OVERSAMPLE/2-1: rx_s==0 -> DATA, cnt=0, bit_idx=0, latch parity.
  - Otherwise (glitch) -> IDLE, no outputs change.
- DATA: on tick with cnt==OVERSAMPLE-1 (bit centre), shift in rx_s at MSB side so the first bit ends at bit 0, cnt=0, bit_idx++.
  - After bit DATA_WIDTH-1 -> PARITY if latched parity=1, else STOP.
- PARITY: at bit centre, perr = rx_s XOR (^shift) (even parity: total ones incl. parity bit is even) -> STOP.
- STOP: at bit centre, commit on this same clk edge:
  - rx_out<=shift, valid<=1, parity_err<=perr (0 if parity disabled), frame_err<=~rx_s.
  - rx_s==1 -> IDLE. rx_s==0 -> BREAK.
- BREAK: remain until tick & rx_s==1 -> IDLE. Prevents a low stop/break from being re-detected as a start bit.
- Latency: valid, rx_out and the error flags update on the clk edge of the stop-bit-centre tick, i.e. ~OVERSAMPLE/2 ticks plus 2 clk (synchronizer) after the stop bit's leading edge.
- Handshake: rd=1 with valid=1 clears valid and overrun next edge. rd with valid=0 is ignored. rx_out and the error flags hold until the next commit.
- Commit while valid=1 and rd=0: rx_out overwritten, valid stays 1, overrun<=1 (sticky until rd).
- Commit and rd on the same edge: new word wins, valid stays 1, overrun not set.
- tick=0: FSM and counters frozen. parity changes mid-frame have no effect.
- reset mid-frame: immediate return to reset values; the partial frame is discarded.

Test Plan:
- DATA_WIDTH=8, tick every 2 clk, parity=0, send 0xA5 (bits 1,0,1,0,0,1,0,1) -> valid=1, rx_out=0xA5, parity_err=0, frame_err=0. rd one clk -> valid=0.
- parity=1, send 0xAB with parity bit 1 -> rx_out=0xAB, parity_err=0. Repeat with parity bit 0 -> parity_err=1, rx_out=0xAB.
- rx_in low for 4 ticks then high -> FSM back to IDLE, valid stays 0. A following 0x3C frame is received correctly.
- Frame 0x0F with stop bit 0, line held low 3 bit times -> frame_err=1, rx_out=0x0F, FSM in BREAK, no spurious frame. Line high, then send 0x55 -> rx_out=0x55, frame_err=0.
- Send 0x11 then 0x22 with rd=0 -> rx_out=0x22, valid=1, overrun=1. rd -> valid=0, overrun=0. Separately, rd asserted on the commit edge of 0x33 -> valid=1, overrun=0.
- Assert reset during data bit 4 of 0xFF -> all outputs 0, state IDLE. Next frame 0x81 -> rx_out=0x81, no errors.
